// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer_pkg
// Brief  : Shared LC-3b types for the reorder buffer: opcodes, CDB, ROB entry.
// Rev    : 1.0
// ============================================================================
package reorder_buffer_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 3;
  localparam int ROB_DEPTH  = 1 << TAG_WIDTH;

  typedef logic [DATA_WIDTH-1:0] lc3b_word;
  typedef logic [TAG_WIDTH-1:0]  lc3b_rob_addr;
  typedef logic [2:0]            lc3b_reg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010, OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100, OP_SHF = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } lc3b_cdb;

  typedef struct packed {
    logic       busy;
    logic       ready;
    lc3b_opcode opcode;
    lc3b_reg    dest;
    lc3b_word   value;
    logic       mispredict;
  } lc3b_rob_entry_t;

  function automatic logic writes_regfile(input lc3b_opcode op);
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LDR, OP_LEA, OP_JSR: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // These opcodes carry their final value at issue time, so no CDB is awaited.
  function automatic logic ready_at_alloc(input lc3b_opcode op);
    return (op == OP_LEA) || (op == OP_JSR) || (op == OP_STR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer_if
// Brief  : Issue/CDB/commit signal bundle between the ROB and its neighbours.
// Rev    : 1.0
// ============================================================================
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic         rob_write_enable;
  lc3b_opcode   rob_opcode;
  lc3b_reg      rob_dest;
  lc3b_word     rob_value_in;
  lc3b_cdb      CDB_in;
  lc3b_rob_addr rob_sr1_read_addr;
  lc3b_rob_addr rob_sr2_read_addr;

  logic         rob_full;
  lc3b_rob_addr rob_addr;
  lc3b_word     rob_sr1_value_out;
  logic         rob_sr1_valid_out;
  lc3b_word     rob_sr2_value_out;
  logic         rob_sr2_valid_out;
  logic         commit_reg_we;
  lc3b_reg      commit_dest;
  lc3b_word     commit_value;
  lc3b_rob_addr commit_rob_entry;
  logic         commit_store;
  logic         flush;
  lc3b_word     flush_pc;

  modport master (
    output rob_write_enable, rob_opcode, rob_dest, rob_value_in, CDB_in,
           rob_sr1_read_addr, rob_sr2_read_addr,
    input  rob_full, rob_addr, rob_sr1_value_out, rob_sr1_valid_out,
           rob_sr2_value_out, rob_sr2_valid_out, commit_reg_we, commit_dest,
           commit_value, commit_rob_entry, commit_store, flush, flush_pc
  );

  modport slave (
    input  rob_write_enable, rob_opcode, rob_dest, rob_value_in, CDB_in,
           rob_sr1_read_addr, rob_sr2_read_addr,
    output rob_full, rob_addr, rob_sr1_value_out, rob_sr1_valid_out,
           rob_sr2_value_out, rob_sr2_valid_out, commit_reg_we, commit_dest,
           commit_value, commit_rob_entry, commit_store, flush, flush_pc
  );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer_storage.sv
`default_nettype none
// ============================================================================
// Module : rob_storage
// Brief  : ROB entry array: allocate, CDB and clear write ports, three reads.
// Rev    : 1.0
// ============================================================================
module rob_storage
  import reorder_buffer_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_alloc_en,
  input  wire lc3b_rob_addr     i_alloc_idx,
  input  wire lc3b_rob_entry_t  i_alloc_entry,
  input  wire lc3b_cdb          i_cdb,
  input  wire logic             i_clear_en,
  input  wire lc3b_rob_addr     i_clear_idx,
  input  wire logic             i_clear_all,
  input  wire lc3b_rob_addr     i_sr1_idx,
  input  wire lc3b_rob_addr     i_sr2_idx,
  input  wire lc3b_rob_addr     i_head_idx,
  output lc3b_rob_entry_t       o_sr1_entry,
  output lc3b_rob_entry_t       o_sr2_entry,
  output lc3b_rob_entry_t       o_head_entry
);

  lc3b_rob_entry_t w_entries [ROB_DEPTH];

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_entry
    lc3b_rob_entry_t r_entry;
    logic            w_alloc_here;
    logic            w_clear_here;
    logic            w_cdb_here;

    assign w_alloc_here = i_alloc_en && (i_alloc_idx == lc3b_rob_addr'(i));
    assign w_clear_here = i_clear_en && (i_clear_idx == lc3b_rob_addr'(i));
    assign w_cdb_here   = i_cdb.valid && (i_cdb.tag == lc3b_rob_addr'(i)) && r_entry.busy;

    // Allocation outranks the commit clear: a full ROB may retire and refill
    // the same slot in one cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_entry <= '0;
      end else if (i_clear_all) begin
        r_entry.busy  <= 1'b0;
        r_entry.ready <= 1'b0;
      end else if (w_alloc_here) begin
        r_entry <= i_alloc_entry;
      end else if (w_clear_here) begin
        r_entry.busy  <= 1'b0;
        r_entry.ready <= 1'b0;
      end else if (w_cdb_here) begin
        if (r_entry.opcode == OP_BR) begin
          r_entry.mispredict <= i_cdb.data[0];
        end else begin
          r_entry.value <= i_cdb.data;
        end
        r_entry.ready <= 1'b1;
      end
    end

    assign w_entries[i] = r_entry;
  end

  assign o_sr1_entry  = w_entries[i_sr1_idx];
  assign o_sr2_entry  = w_entries[i_sr2_idx];
  assign o_head_entry = w_entries[i_head_idx];

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer
// Brief  : 8-entry in-order-retire reorder buffer with CDB capture and flush.
// Rev    : 1.0
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  reorder_buffer_if.slave rob
);

  lc3b_rob_addr      r_head;
  lc3b_rob_addr      r_tail;
  logic [TAG_WIDTH:0] r_count;

  lc3b_rob_entry_t w_head_entry;
  lc3b_rob_entry_t w_sr1_entry;
  lc3b_rob_entry_t w_sr2_entry;
  lc3b_rob_entry_t w_alloc_entry;
  logic            w_full;
  logic            w_commit;
  logic            w_flush;
  logic            w_alloc;
  logic            w_reg_we;

  assign w_full   = (r_count == (TAG_WIDTH+1)'(ROB_DEPTH));
  assign w_commit = w_head_entry.busy && w_head_entry.ready && (r_count != '0);
  assign w_flush  = w_commit && (w_head_entry.opcode == OP_BR) && w_head_entry.mispredict;
  assign w_reg_we = w_commit && writes_regfile(w_head_entry.opcode);

  // A full ROB still accepts an allocation in the cycle its head retires.
  assign w_alloc  = rob.rob_write_enable && (!w_full || w_commit) && !w_flush;

  always_comb begin
    w_alloc_entry            = '0;
    w_alloc_entry.busy       = 1'b1;
    w_alloc_entry.ready      = ready_at_alloc(rob.rob_opcode);
    w_alloc_entry.opcode     = rob.rob_opcode;
    w_alloc_entry.dest       = rob.rob_dest;
    w_alloc_entry.value      = rob.rob_value_in;
    w_alloc_entry.mispredict = 1'b0;
  end

  rob_storage u_storage (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_en   (w_alloc),
    .i_alloc_idx  (r_tail),
    .i_alloc_entry(w_alloc_entry),
    .i_cdb        (rob.CDB_in),
    .i_clear_en   (w_commit),
    .i_clear_idx  (r_head),
    .i_clear_all  (w_flush),
    .i_sr1_idx    (rob.rob_sr1_read_addr),
    .i_sr2_idx    (rob.rob_sr2_read_addr),
    .i_head_idx   (r_head),
    .o_sr1_entry  (w_sr1_entry),
    .o_sr2_entry  (w_sr2_entry),
    .o_head_entry (w_head_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) r_head <= r_head + 1'b1;
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rob.rob_full          = w_full;
  assign rob.rob_addr          = r_tail;
  assign rob.rob_sr1_value_out = w_sr1_entry.value;
  assign rob.rob_sr1_valid_out = w_sr1_entry.busy && w_sr1_entry.ready;
  assign rob.rob_sr2_value_out = w_sr2_entry.value;
  assign rob.rob_sr2_valid_out = w_sr2_entry.busy && w_sr2_entry.ready;
  assign rob.commit_reg_we     = w_reg_we;
  assign rob.commit_dest       = w_reg_we ? w_head_entry.dest  : '0;
  assign rob.commit_value      = w_reg_we ? w_head_entry.value : '0;
  assign rob.commit_rob_entry  = w_commit ? r_head : '0;
  assign rob.commit_store      = w_commit && (w_head_entry.opcode == OP_STR);
  assign rob.flush             = w_flush;
  assign rob.flush_pc          = w_flush ? w_head_entry.value : '0;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_reorder_buffer
// Brief  : Vector table, directed corner sequences and random model check.
// Rev    : 1.0
// ============================================================================
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  reorder_buffer_if rob_if ();

  reorder_buffer dut (
    .clk(clk),
    .rst(rst),
    .rob(rob_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;   lc3b_opcode op;   logic [2:0] dest; logic [15:0] val;
    logic       cv;   logic [2:0] ctag; logic [15:0] cdata;
    logic [2:0] sr1;
    logic       e_full; logic [2:0] e_addr; logic e_we; logic [2:0] e_dest; logic [15:0] e_value;
    logic       e_store; logic e_flush; logic [15:0] e_fpc; logic e_v1; logic [15:0] e_val1;
  } vec_t;

  typedef struct {
    int         tag;
    lc3b_opcode op;
    logic [2:0] dest;
    logic [15:0] val;
    logic       rdy;
    logic       misp;
  } ment_t;

  vec_t  vecs [11];
  ment_t q [$];
  int    next_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rob_if.rob_write_enable  = 1'b0;
    rob_if.rob_opcode        = OP_ADD;
    rob_if.rob_dest          = '0;
    rob_if.rob_value_in      = '0;
    rob_if.CDB_in            = '0;
    rob_if.rob_sr1_read_addr = '0;
    rob_if.rob_sr2_read_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input lc3b_opcode op, input logic [2:0] dest, input logic [15:0] val);
    rob_if.rob_write_enable = 1'b1;
    rob_if.rob_opcode       = op;
    rob_if.rob_dest         = dest;
    rob_if.rob_value_in     = val;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
    rob_if.CDB_in = '{valid: 1'b1, tag: tag, data: data};
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // we op dest val | cv ctag cdata | sr1 | full addr we dest value store flush fpc v1 val1
    vecs[0]  = '{1, OP_ADD, 3, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};
    vecs[1]  = '{0, OP_ADD, 0, 16'h0,    1, 0, 16'h1234, 0, 0, 1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};
    vecs[2]  = '{0, OP_ADD, 0, 16'h0,    0, 0, 16'h0,    0, 0, 1, 1, 3, 16'h1234, 0, 0, 16'h0,    1, 16'h1234};
    vecs[3]  = '{1, OP_LEA, 5, 16'h3008, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};
    vecs[4]  = '{1, OP_STR, 2, 16'h0,    0, 0, 16'h0,    1, 0, 2, 1, 5, 16'h3008, 0, 0, 16'h0,    1, 16'h3008};
    vecs[5]  = '{0, OP_ADD, 0, 16'h0,    0, 0, 16'h0,    2, 0, 3, 0, 0, 16'h0,    1, 0, 16'h0,    1, 16'h0};
    vecs[6]  = '{1, OP_BR,  0, 16'h4000, 0, 0, 16'h0,    2, 0, 3, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};
    vecs[7]  = '{1, OP_ADD, 1, 16'h0,    0, 0, 16'h0,    3, 0, 4, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};
    vecs[8]  = '{1, OP_ADD, 2, 16'h0,    1, 3, 16'h0001, 3, 0, 5, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};
    vecs[9]  = '{1, OP_ADD, 4, 16'h0,    0, 0, 16'h0,    3, 0, 6, 0, 0, 16'h0,    0, 1, 16'h4000, 1, 16'h4000};
    vecs[10] = '{0, OP_ADD, 0, 16'h0,    0, 0, 16'h0,    3, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 16'h0};

    reset_dut();
    #1;
    check("reset full",      rob_if.rob_full, 0);
    check("reset addr",      rob_if.rob_addr, 0);
    check("reset reg_we",    rob_if.commit_reg_we, 0);
    check("reset dest",      rob_if.commit_dest, 0);
    check("reset value",     rob_if.commit_value, 0);
    check("reset rob_entry", rob_if.commit_rob_entry, 0);
    check("reset store",     rob_if.commit_store, 0);
    check("reset flush",     rob_if.flush, 0);
    check("reset flush_pc",  rob_if.flush_pc, 0);
    check("reset sr1 valid", rob_if.rob_sr1_valid_out, 0);
    check("reset sr1 value", rob_if.rob_sr1_value_out, 0);

    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      if (vecs[i].we) alloc(vecs[i].op, vecs[i].dest, vecs[i].val);
      if (vecs[i].cv) cdb(vecs[i].ctag, vecs[i].cdata);
      rob_if.rob_sr1_read_addr = vecs[i].sr1;
      rob_if.rob_sr2_read_addr = vecs[i].sr1;
      #1;
      check($sformatf("v%0d full", i),   rob_if.rob_full, vecs[i].e_full);
      check($sformatf("v%0d addr", i),   rob_if.rob_addr, vecs[i].e_addr);
      check($sformatf("v%0d reg_we", i), rob_if.commit_reg_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        check($sformatf("v%0d dest", i),  rob_if.commit_dest, vecs[i].e_dest);
        check($sformatf("v%0d value", i), rob_if.commit_value, vecs[i].e_value);
      end
      check($sformatf("v%0d store", i), rob_if.commit_store, vecs[i].e_store);
      check($sformatf("v%0d flush", i), rob_if.flush, vecs[i].e_flush);
      if (vecs[i].e_flush) check($sformatf("v%0d flush_pc", i), rob_if.flush_pc, vecs[i].e_fpc);
      check($sformatf("v%0d sr1 valid", i), rob_if.rob_sr1_valid_out, vecs[i].e_v1);
      check($sformatf("v%0d sr2 valid", i), rob_if.rob_sr2_valid_out, vecs[i].e_v1);
      if (vecs[i].e_v1) check($sformatf("v%0d sr1 value", i), rob_if.rob_sr1_value_out, vecs[i].e_val1);
      tick();
    end

    // Fill to capacity, overflow attempt, then retire-and-refill while full.
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      alloc(OP_ADD, 3'(i), 16'h0);
      tick();
    end
    idle_inputs();
    #1;
    check("fill full", rob_if.rob_full, 1);
    check("fill addr", rob_if.rob_addr, 0);
    alloc(OP_ADD, 3'd6, 16'h0);
    tick();
    idle_inputs();
    #1;
    check("overflow full", rob_if.rob_full, 1);
    check("overflow addr", rob_if.rob_addr, 0);
    check("overflow sr1 valid", rob_if.rob_sr1_valid_out, 0);
    cdb(3'd0, 16'hAAAA);
    tick();
    idle_inputs();
    #1;
    check("full commit we",    rob_if.commit_reg_we, 1);
    check("full commit entry", rob_if.commit_rob_entry, 0);
    check("full commit value", rob_if.commit_value, 16'hAAAA);
    alloc(OP_ADD, 3'd7, 16'h0);
    tick();
    idle_inputs();
    #1;
    check("refill full",   rob_if.rob_full, 1);
    check("refill addr",   rob_if.rob_addr, 1);
    check("refill reg_we", rob_if.commit_reg_we, 0);
    check("refill tag0 valid", rob_if.rob_sr1_valid_out, 0);
    cdb(3'd1, 16'h5555);
    tick();
    idle_inputs();
    #1;
    check("head1 entry", rob_if.commit_rob_entry, 1);
    check("head1 dest",  rob_if.commit_dest, 1);
    check("head1 value", rob_if.commit_value, 16'h5555);

    // Asynchronous reset with five busy entries and a pending commit.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      alloc(OP_ADD, 3'(i + 1), 16'h0);
      tick();
    end
    idle_inputs();
    cdb(3'd0, 16'hBEEF);
    tick();
    idle_inputs();
    #1;
    check("pre-rst pending", rob_if.commit_reg_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst full",   rob_if.rob_full, 0);
    check("rst addr",   rob_if.rob_addr, 0);
    check("rst reg_we", rob_if.commit_reg_we, 0);
    check("rst dest",   rob_if.commit_dest, 0);
    check("rst value",  rob_if.commit_value, 0);
    check("rst store",  rob_if.commit_store, 0);
    check("rst flush",  rob_if.flush, 0);
    tick();
    rst = 1'b0;

    // Random traffic against a program-order queue model.
    reset_dut();
    q.delete();
    next_tag = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic       we, cv, commit, exp_we, exp_flush, accept, found, exp_v;
      lc3b_opcode op, hop;
      logic [2:0] dest, ctag, sr1, sr2;
      logic [15:0] val, cdata, exp_val;

      we    = ($urandom % 4) != 0;
      op    = lc3b_opcode'($urandom_range(0, 15));
      dest  = 3'($urandom);
      val   = 16'($urandom);
      cv    = ($urandom % 2) != 0;
      ctag  = (q.size() > 0 && ($urandom % 4) != 0) ? 3'(q[$urandom % q.size()].tag) : 3'($urandom);
      cdata = 16'($urandom);
      sr1   = 3'($urandom);
      sr2   = 3'($urandom);

      idle_inputs();
      if (we) alloc(op, dest, val);
      if (cv) cdb(ctag, cdata);
      rob_if.rob_sr1_read_addr = sr1;
      rob_if.rob_sr2_read_addr = sr2;
      #1;

      commit    = (q.size() > 0) && q[0].rdy;
      hop       = commit ? q[0].op : OP_RTI;
      exp_we    = commit && (hop inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LDR, OP_LEA, OP_JSR});
      exp_flush = commit && (hop == OP_BR) && q[0].misp;

      check("rnd full",   rob_if.rob_full, q.size() == 8);
      check("rnd addr",   rob_if.rob_addr, next_tag);
      check("rnd reg_we", rob_if.commit_reg_we, exp_we);
      if (exp_we) begin
        check("rnd dest",  rob_if.commit_dest, q[0].dest);
        check("rnd value", rob_if.commit_value, q[0].val);
      end
      if (commit) check("rnd rob_entry", rob_if.commit_rob_entry, q[0].tag);
      check("rnd store", rob_if.commit_store, commit && (hop == OP_STR));
      check("rnd flush", rob_if.flush, exp_flush);
      if (exp_flush) check("rnd flush_pc", rob_if.flush_pc, q[0].val);

      found = 1'b0; exp_v = 1'b0; exp_val = '0;
      foreach (q[k]) if (q[k].tag == int'(sr1)) begin found = 1'b1; exp_v = q[k].rdy; exp_val = q[k].val; end
      check("rnd sr1 valid", rob_if.rob_sr1_valid_out, found && exp_v);
      if (found && exp_v) check("rnd sr1 value", rob_if.rob_sr1_value_out, exp_val);
      found = 1'b0; exp_v = 1'b0; exp_val = '0;
      foreach (q[k]) if (q[k].tag == int'(sr2)) begin found = 1'b1; exp_v = q[k].rdy; exp_val = q[k].val; end
      check("rnd sr2 valid", rob_if.rob_sr2_valid_out, found && exp_v);
      if (found && exp_v) check("rnd sr2 value", rob_if.rob_sr2_value_out, exp_val);

      if (exp_flush) begin
        q.delete();
        next_tag = 0;
      end else begin
        accept = we && (q.size() < 8 || commit);
        if (cv) begin
          foreach (q[k]) if (q[k].tag == int'(ctag)) begin
            if (q[k].op == OP_BR) q[k].misp = cdata[0];
            else                  q[k].val  = cdata;
            q[k].rdy = 1'b1;
          end
        end
        if (commit) void'(q.pop_front());
        if (accept) begin
          q.push_back('{tag: next_tag, op: op, dest: dest, val: val,
                        rdy: (op inside {OP_LEA, OP_JSR, OP_STR}), misp: 1'b0});
          next_tag = (next_tag + 1) % 8;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
